// File: rtl/rv32_lsu_pkg.sv
// Shared encodings for the RV32 split load/store unit: access sizes,
// fault causes, FSM states and the per-size byte-mask helper.
package rv32_lsu_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS      = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } err_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'h1;
      SIZE_HALF: m = 4'h3;
      SIZE_WORD: m = 4'hF;
      default:   m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rv32_mod_lsu_align.sv
// Combinational lane logic: shifts store data into two bus beats and
// merges/extends the two read beats into a right-aligned load result.
module rv32_mod_lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] beat0_i,
  input  logic [31:0] beat1_i,
  output logic [31:0] st_lo_o,
  output logic [31:0] st_hi_o,
  output logic [31:0] ld_data_o
);

  logic [63:0] st_wide_s;
  logic [63:0] ld_wide_s;

  // The 64-bit window spans both beats; a shift of 8*off lines the lanes up.
  always_comb begin
    st_wide_s = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
    ld_wide_s = {beat1_i, beat0_i} >> {off_i, 3'b000};
    st_lo_o   = st_wide_s[31:0];
    st_hi_o   = st_wide_s[63:32];
    case (size_i)
      SIZE_BYTE: ld_data_o = {{24{sgn_i & ld_wide_s[7]}}, ld_wide_s[7:0]};
      SIZE_HALF: ld_data_o = {{16{sgn_i & ld_wide_s[15]}}, ld_wide_s[15:0]};
      default:   ld_data_o = ld_wide_s[31:0];
    endcase
  end

endmodule

// File: rtl/rv32_mod_load_store_unit_split.sv
// RV32 load/store unit: registers a hart request, runs one or two aligned
// bus beats with a held req/ack handshake, and reports faults with a cause.
module rv32_mod_load_store_unit_split
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int MISALIGNED_EN = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req_type,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              valid,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic              stall,
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_ack,
  input  logic              data_err,
  output logic [3:0]        data_be,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_data_o,
  input  logic [31:0]       data_data_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e            state_q, state_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              sgn_q, sgn_d, wr_q, wr_d;
  logic [7:0]        mask_q, mask_d;
  logic [31:0]       beat0_q, beat0_d, data_o_q, data_o_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d, err_q, err_d;
  err_cause_e        cause_q, cause_d;
  logic              req_q, req_d, bwr_q, bwr_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [31:0]       bdata_q, bdata_d;

  logic [7:0]  mask_in_s;
  logic [1:0]  off_s, size_s;
  logic [31:0] beat0_s, st_lo_s, st_hi_s, ld_data_s;
  logic        split_s, timeout_s, unused_s;

  assign unused_s  = req_type[2];
  assign mask_in_s = {4'h0, size_mask(req_type[1:0])} << address[1:0];
  assign off_s     = (state_q == ST_IDLE) ? address[1:0] : off_q;
  assign size_s    = (state_q == ST_IDLE) ? req_type[1:0] : size_q;
  assign beat0_s   = (state_q == ST_ACC1) ? beat0_q : data_data_i;
  assign split_s   = (mask_q[7:4] != 4'h0);
  assign timeout_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign stall     = (req_type[1:0] != SIZE_NONE) && (state_q != ST_RESP);

  rv32_mod_lsu_align u_align (
    .off_i     (off_s),
    .size_i    (size_s),
    .sgn_i     (sgn_q),
    .wdata_i   (data_i),
    .beat0_i   (beat0_s),
    .beat1_i   (data_data_i),
    .st_lo_o   (st_lo_s),
    .st_hi_o   (st_hi_s),
    .ld_data_o (ld_data_s)
  );

  // Next-state and registered-output logic for the access FSM.
  always_comb begin
    state_d  = state_q;  off_d   = off_q;   size_d = size_q;  sgn_d = sgn_q;
    wr_d     = wr_q;     mask_d  = mask_q;  beat0_d = beat0_q;
    data_o_d = data_o_q; cnt_d   = cnt_q;   valid_d = 1'b0;   err_d = 1'b0;
    cause_d  = cause_q;  req_d   = req_q;   bwr_d  = bwr_q;   be_d  = be_q;
    baddr_d  = baddr_q;  bdata_d = bdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_type[1:0] != SIZE_NONE) begin
          off_d  = address[1:0];
          size_d = req_type[1:0];
          sgn_d  = req_type[3];
          wr_d   = wr;
          mask_d = mask_in_s;
          if ((mask_in_s[7:4] != 4'h0) && (MISALIGNED_EN == 0)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_ACC0;
            req_d   = 1'b1;
            bwr_d   = wr;
            be_d    = mask_in_s[3:0];
            baddr_d = {address[ADDR_W-1:2], 2'b00};
            bdata_d = st_lo_s;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC0, ST_ACC1: begin
        if (data_err) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = CAUSE_BUS;
        end else if (data_ack && split_s && (state_q == ST_ACC0)) begin
          // Low beat done: keep data_req high and move to the next word.
          state_d = ST_ACC1;
          beat0_d = data_data_i;
          be_d    = mask_q[7:4];
          baddr_d = baddr_q + ADDR_W'(32'd4);
          bdata_d = st_hi_s;
          cnt_d   = '0;
        end else if (data_ack) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          valid_d = 1'b1;
          data_o_d = wr_q ? data_o_q : ld_data_s;
        end else if (timeout_s) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;  off_q   <= 2'b00;  size_q  <= 2'b00;  sgn_q <= 1'b0;
      wr_q     <= 1'b0;     mask_q  <= 8'h00;  beat0_q <= 32'h0;  data_o_q <= 32'h0;
      cnt_q    <= '0;       valid_q <= 1'b0;   err_q   <= 1'b0;   cause_q <= CAUSE_NONE;
      req_q    <= 1'b0;     bwr_q   <= 1'b0;   be_q    <= 4'h0;
      baddr_q  <= '0;       bdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;  off_q   <= off_d;  size_q  <= size_d;  sgn_q <= sgn_d;
      wr_q     <= wr_d;     mask_q  <= mask_d; beat0_q <= beat0_d; data_o_q <= data_o_d;
      cnt_q    <= cnt_d;    valid_q <= valid_d; err_q  <= err_d;   cause_q <= cause_d;
      req_q    <= req_d;    bwr_q   <= bwr_d;  be_q    <= be_d;
      baddr_q  <= baddr_d;  bdata_q <= bdata_d;
    end
  end

  assign data_o      = data_o_q;
  assign valid       = valid_q;
  assign err         = err_q;
  assign err_cause   = cause_q;
  assign data_req    = req_q;
  assign data_wr     = bwr_q;
  assign data_be     = be_q;
  assign data_addr   = baddr_q;
  assign data_data_o = bdata_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit_split.sv
// Scoreboard bench: stimulus pushes expected responses and bus beats; a bus
// responder and a response monitor pop and compare independently.
module tb_rv32_mod_load_store_unit_split;

  typedef struct {
    logic        is_err;
    logic [1:0]  cause;
    logic        chk_data;
    logic [31:0] data;
    int          lat;
    int          issue;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;   // 0 ack, 1 err, 2 err+ack
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_type_a, req_type_b;
  logic        wr;
  logic [31:0] address, data_i, data_data_i;
  logic        data_ack, data_err;
  logic        ack_b, err_b;

  logic [31:0] data_o_a, data_o_b, data_addr_a, data_addr_b, data_data_o_a, data_data_o_b;
  logic        valid_a, valid_b, err_a, err_o_b, stall_a, stall_b;
  logic        data_req_a, data_req_b, data_wr_a, data_wr_b;
  logic [1:0]  cause_a, cause_b;
  logic [3:0]  be_a, be_b;

  exp_t  exp_a_q[$], exp_b_q[$];
  beat_t beat_q[$];
  exp_t  ea, eb;
  beat_t bt;
  int    errors = 0, checks = 0, cyc = 0, stray_req = 0, b_req_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_mod_load_store_unit_split #(.ADDR_W(32), .MISALIGNED_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .req_type(req_type_a), .wr(wr), .address(address),
    .data_i(data_i), .data_o(data_o_a), .valid(valid_a), .err(err_a), .err_cause(cause_a),
    .stall(stall_a), .data_req(data_req_a), .data_wr(data_wr_a), .data_ack(data_ack),
    .data_err(data_err), .data_be(be_a), .data_addr(data_addr_a),
    .data_data_o(data_data_o_a), .data_data_i(data_data_i));

  rv32_mod_load_store_unit_split #(.ADDR_W(32), .MISALIGNED_EN(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .req_type(req_type_b), .wr(wr), .address(address),
    .data_i(data_i), .data_o(data_o_b), .valid(valid_b), .err(err_o_b), .err_cause(cause_b),
    .stall(stall_b), .data_req(data_req_b), .data_wr(data_wr_b), .data_ack(ack_b),
    .data_err(err_b), .data_be(be_b), .data_addr(data_addr_b),
    .data_data_o(data_data_o_b), .data_data_i(data_data_i));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic w,
                           input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp);
    beat_t b;
    b.addr = a; b.be = be; b.wr = w; b.wdata = wd; b.rdata = rd; b.resp = resp;
    beat_q.push_back(b);
  endtask

  task automatic issue(input bit sel_b, input logic [3:0] rt, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic is_err, input logic [1:0] cause,
                       input logic chk, input logic [31:0] d, input int lat);
    exp_t e;
    bit   done;
    @(negedge clk);
    wr = w; address = a; data_i = wd;
    e.is_err = is_err; e.cause = cause; e.chk_data = chk; e.data = d; e.lat = lat; e.issue = cyc;
    if (sel_b) begin req_type_b = rt; exp_b_q.push_back(e); end
    else begin req_type_a = rt; exp_a_q.push_back(e); end
    #1 check("stall", 32'(sel_b ? stall_b : stall_a), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sel_b ? (valid_b || err_o_b) : (valid_a || err_a)) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no response for request at 0x%08h", a);
    end
    req_type_a = 4'h0; req_type_b = 4'h0;
  endtask

  // Bus responder for dut_a: checks each presented beat and answers it.
  always @(negedge clk) begin
    data_ack = 1'b0; data_err = 1'b0;
    if (reset && data_req_a) begin
      if (beat_q.size() > 0) begin
        bt = beat_q.pop_front();
        check("beat_addr", data_addr_a, bt.addr);
        check("beat_be", 32'(be_a), 32'(bt.be));
        check("beat_wr", 32'(data_wr_a), 32'(bt.wr));
        if (bt.wr) check("beat_wdata", data_data_o_a, bt.wdata);
        data_data_i = bt.rdata;
        data_ack = (bt.resp != 2'd1);
        data_err = (bt.resp != 2'd0);
      end else begin
        stray_req++;
      end
    end
  end

  // Response monitors: pop expected entries when a DUT pulses valid/err.
  always @(negedge clk) begin
    if (data_req_b) b_req_seen++;
    if (reset && (valid_a || err_a)) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp_a: valid=%0d err=%0d", valid_a, err_a);
      end else begin
        ea = exp_a_q.pop_front();
        check("a_excl", 32'(valid_a & err_a), 32'd0);
        check("a_err", 32'(err_a), 32'(ea.is_err));
        if (ea.is_err) check("a_cause", 32'(cause_a), 32'(ea.cause));
        if (ea.chk_data) check("a_data_o", data_o_a, ea.data);
        check("a_latency", 32'(cyc - ea.issue), 32'(ea.lat));
      end
    end
    if (reset && (valid_b || err_o_b)) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp_b: valid=%0d err=%0d", valid_b, err_o_b);
      end else begin
        eb = exp_b_q.pop_front();
        check("b_err", 32'(err_o_b), 32'(eb.is_err));
        check("b_cause", 32'(cause_b), 32'(eb.cause));
        check("b_latency", 32'(cyc - eb.issue), 32'(eb.lat));
      end
    end
  end

  initial begin
    reset = 1'b0; req_type_a = 4'h0; req_type_b = 4'h0; wr = 1'b0;
    address = 32'h0; data_i = 32'h0; data_data_i = 32'h0; ack_b = 1'b0; err_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_o", data_o_a, 32'h0);
    check("rst_valid_err", {30'd0, valid_a, err_a}, 32'h0);
    check("rst_cause", 32'(cause_a), 32'h0);
    check("rst_bus", {27'd0, data_req_a, data_wr_a, be_a}, 32'h0);
    check("rst_addr", data_addr_a, 32'h0);
    check("rst_wdata", data_data_o_a, 32'h0);
    reset = 1'b1;

    // Aligned signed and unsigned byte loads at 0x103
    push_beat(32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h80FF_FFFF, 2'd0);
    issue(0, 4'b1001, 1'b0, 32'h0000_0103, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FF80, 2);
    push_beat(32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h80FF_FFFF, 2'd0);
    issue(0, 4'b0001, 1'b0, 32'h0000_0103, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000_0080, 2);
    // Misaligned word store: two beats, data_o keeps the last load result
    push_beat(32'h0000_0200, 4'b1100, 1'b1, 32'hCCDD_0000, 32'h0, 2'd0);
    push_beat(32'h0000_0204, 4'b0011, 1'b1, 32'h0000_AABB, 32'h0, 2'd0);
    issue(0, 4'b0011, 1'b1, 32'h0000_0202, 32'hAABB_CCDD, 1'b0, 2'b00, 1'b1, 32'h0000_0080, 3);
    // Misaligned half load wrapping the address space
    push_beat(32'hFFFF_FFFC, 4'b1000, 1'b0, 32'h0, 32'hAB00_0000, 2'd0);
    push_beat(32'h0000_0000, 4'b0001, 1'b0, 32'h0, 32'h0000_00CD, 2'd0);
    issue(0, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000_CDAB, 3);
    // Signed half in the upper lanes, then aligned word
    push_beat(32'h0000_0010, 4'b1100, 1'b0, 32'h0, 32'h8001_0000, 2'd0);
    issue(0, 4'b1010, 1'b0, 32'h0000_0012, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_8001, 2);
    push_beat(32'h0000_0040, 4'b1111, 1'b0, 32'h0, 32'h1234_5678, 2'd0);
    issue(0, 4'b0011, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 2'b00, 1'b1, 32'h1234_5678, 2);
    // Bus error on beat1 of a split load; err+ack on an aligned load
    push_beat(32'h0000_0300, 4'b1110, 1'b0, 32'h0, 32'h5555_5555, 2'd0);
    push_beat(32'h0000_0304, 4'b0001, 1'b0, 32'h0, 32'h0, 2'd1);
    issue(0, 4'b0011, 1'b0, 32'h0000_0301, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 3);
    push_beat(32'h0000_0050, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'd2);
    issue(0, 4'b0011, 1'b0, 32'h0000_0050, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 2);
    // Byte store; faulted loads must not have touched data_o
    push_beat(32'h0000_0060, 4'b0010, 1'b1, 32'h0000_5500, 32'h0, 2'd0);
    issue(0, 4'b0001, 1'b1, 32'h0000_0061, 32'h0000_0055, 1'b0, 2'b00, 1'b1, 32'h1234_5678, 2);
    // Misalignment disallowed: immediate fault, no bus activity
    issue(1, 4'b0011, 1'b0, 32'h0000_0001, 32'h0, 1'b1, 2'b01, 1'b0, 32'h0, 1);
    check("b_no_bus_req", 32'(b_req_seen), 32'd0);

    // Reset in the middle of ACC0: data_req drops at once, no response
    @(negedge clk);
    req_type_a = 4'b0011; wr = 1'b0; address = 32'h0000_0080;
    repeat (2) @(negedge clk);
    check("pre_rst_req", 32'(data_req_a), 32'd1);
    #2 reset = 1'b0;
    #1 check("rst_async_req", 32'(data_req_a), 32'd0);
    check("rst_async_valid", 32'(valid_a), 32'd0);
    req_type_a = 4'h0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_data_o", data_o_a, 32'h0);

    // No ack: data_req held for 4 cycles, then a timeout fault
    stray_req = 0;
    issue(0, 4'b0011, 1'b0, 32'h0000_0090, 32'h0, 1'b1, 2'b11, 1'b0, 32'h0, 5);
    check("timeout_req_cycles", 32'(stray_req), 32'd4);
    repeat (3) @(negedge clk);
    check("sb_a_empty", 32'(exp_a_q.size()), 32'd0);
    check("beats_consumed", 32'(beat_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
